// File: rtl/interrupt_collector_if.sv
// Host-side interrupt presentation channel: one interrupt at a time is
// offered with a level valid and completed by a single-cycle ack pulse.
interface interrupt_collector_if #(
    parameter int INT_BITS = 64,
    parameter int CTXW     = 9,
    parameter int ENG_ID_W = 2
);
    logic                valid;
    logic [INT_BITS-1:0] src;
    logic [CTXW-1:0]     ctx;
    logic [ENG_ID_W-1:0] eng;
    logic                ack;

    // Collector side: presents the interrupt, receives completion.
    modport master (output valid, src, ctx, eng, input ack);
    // Host side: consumes the interrupt, signals completion.
    modport slave  (input valid, src, ctx, eng, output ack);
endinterface

// File: rtl/interrupt_collector.sv
// Interrupt collector: captures per-engine request pulses with their
// src/ctx, arbitrates round-robin among unmasked pending engines, presents
// one interrupt to the host and returns a one-cycle ack to the engine.
module interrupt_collector #(
    parameter int N_ENG    = 4,
    parameter int ENG_ID_W = 2,
    parameter int INT_BITS = 64,
    parameter int CTXW     = 9
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [N_ENG-1:0]          i_eng_interrupt_req,
    input  logic [N_ENG*INT_BITS-1:0] i_eng_interrupt_src,
    input  logic [N_ENG*CTXW-1:0]     i_eng_interrupt_ctx,
    output logic [N_ENG-1:0]          o_eng_interrupt_ack,
    interrupt_collector_if.master     host,
    input  logic [N_ENG-1:0]          i_eng_mask,
    input  logic                      i_err_clear,
    output logic [N_ENG-1:0]          o_err_overflow,
    output logic                      o_err_spurious_ack
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t              r_state;
    logic [N_ENG-1:0]    r_pending;
    logic [INT_BITS-1:0] r_src [N_ENG];
    logic [CTXW-1:0]     r_ctx [N_ENG];
    logic [ENG_ID_W-1:0] r_last_grant;
    logic                r_valid;
    logic [INT_BITS-1:0] r_host_src;
    logic [CTXW-1:0]     r_host_ctx;
    logic [ENG_ID_W-1:0] r_host_eng;
    logic [N_ENG-1:0]    r_eng_ack;
    logic [N_ENG-1:0]    r_err_overflow;
    logic                r_err_spurious;

    logic [N_ENG-1:0]    w_eligible;
    logic                w_found;
    logic [ENG_ID_W-1:0] w_grant;
    int                  w_idx;
    logic                w_host_done;
    logic [N_ENG-1:0]    w_ack_clear;
    logic [N_ENG-1:0]    w_take;
    logic [N_ENG-1:0]    w_ovf_set;

    // Round-robin search: first eligible engine after the last one served.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        w_eligible = r_pending & ~i_eng_mask;
        w_found    = 1'b0;
        w_grant    = '0;
        w_idx      = 0;
        for (int k = 1; k <= N_ENG; k++) begin
            w_idx = (int'(r_last_grant) + k) % N_ENG;
            if (!w_found && w_eligible[w_idx]) begin
                w_found = 1'b1;
                w_grant = ENG_ID_W'(w_idx);
            end
        end
    end

    // Capture decode: the completing engine is cleared before a new request
    // is considered, so a same-cycle re-request is accepted, not an overflow.
    always_comb begin
        w_host_done = (r_state == S_ISSUE) && host.ack;
        w_ack_clear = w_host_done ? (N_ENG'(1) << r_host_eng) : '0;
        w_take      = i_eng_interrupt_req & (~r_pending | w_ack_clear);
        w_ovf_set   = i_eng_interrupt_req & r_pending & ~w_ack_clear;
    end

    // Pending flags, per-engine src/ctx latches and sticky overflow flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pending      <= '0;
            // NOTE: the src/ctx latches are reset too, so nothing stale can
            // ever be loaded onto the host outputs after a reset.
            for (int i = 0; i < N_ENG; i++) begin
                r_src[i] <= '0;
                r_ctx[i] <= '0;
            end
            r_err_overflow <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            r_pending <= (r_pending & ~w_ack_clear) | i_eng_interrupt_req;
            for (int i = 0; i < N_ENG; i++) begin
                if (w_take[i]) begin
                    r_src[i] <= i_eng_interrupt_src[i*INT_BITS +: INT_BITS];
                    r_ctx[i] <= i_eng_interrupt_ctx[i*CTXW +: CTXW];
                end
            end
            // A new error in the clearing cycle still leaves its flag set.
            r_err_overflow <= (i_err_clear ? '0 : r_err_overflow) | w_ovf_set;
        end
    end

    // Presentation FSM with registered host outputs and engine ack pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_valid        <= 1'b0;
            r_host_src     <= '0;
            r_host_ctx     <= '0;
            r_host_eng     <= '0;
            r_last_grant   <= '0;
            r_eng_ack      <= '0;
            r_err_spurious <= 1'b0;
        end else begin
            r_eng_ack      <= '0;
            r_err_spurious <= (i_err_clear ? 1'b0 : r_err_spurious)
                              | (host.ack && (r_state != S_ISSUE));
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_host_src <= r_src[w_grant];
                        r_host_ctx <= r_ctx[w_grant];
                        r_host_eng <= w_grant;
                        r_valid    <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Masking the granted engine here does not abort it.
                    if (host.ack) begin
                        r_eng_ack    <= N_ENG'(1) << r_host_eng;
                        r_last_grant <= r_host_eng;
                        r_valid      <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign host.valid          = r_valid;
    assign host.src            = r_host_src;
    assign host.ctx            = r_host_ctx;
    assign host.eng            = r_host_eng;
    assign o_eng_interrupt_ack = r_eng_ack;
    assign o_err_overflow      = r_err_overflow;
    assign o_err_spurious_ack  = r_err_spurious;

endmodule
